ahb_sram_slave: RTL
===================

Name: ahb_sram_slave

Overview:
AHB-Lite memory slave that sits directly upstream of the slave-response mux. It drives one slave's HRDATA/HRESP/HREADY input to that mux. It provides word-addressed SRAM with byte, halfword and word access, a parameterisable number of wait states, and a two-cycle ERROR response for illegal accesses. Two instances, on mux inputs 0 and 1, form the default system memory map.

Parameters:
DATA_WIDTH, 32, data bus width; only 32 is supported.
ADDR_WIDTH, 32, HADDR width.
MEM_DEPTH, 256, number of 32-bit words; must be a power of 2.
WAIT_STATES, 0, wait cycles (HREADYOUT=0) inserted before every OKAY data phase; range 0-7.

Ports:
HCLK  in  1  bus clock; all logic on the rising edge.
HRESET  in  1  synchronous, active-high reset.
HSEL  in  1  slave select from the decoder.
HADDR  in  ADDR_WIDTH  byte address.
HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ.
HWRITE  in  1  1 = write.
HSIZE  in  3  000 = byte, 001 = half, 010 = word; anything else is illegal.
HWDATA  in  DATA_WIDTH  write data; valid in the data phase.
HREADY  in  1  bus-level ready, fed back from the mux output.
HRDATA  out  DATA_WIDTH  read data; goes to the mux HRDATAx input.
HREADYOUT  out  1  slave ready; goes to the mux HREADYx input.
HRESP  out  1  0 = OKAY, 1 = ERROR; goes to the mux HRESPx input.

Behaviour:
- Reset: HREADYOUT=1, HRESP=0, HRDATA=0, state IDLE, wait counter 0, pending-transfer flags cleared. Memory contents are not reset.
- Address phase accept: occurs on an edge with HSEL & HREADY & HTRANS[1]. The block registers addr, write, size, an error flag and a valid flag. Any other edge with HREADY=1 clears valid, so IDLE/BUSY/unselected cycles get a zero-wait OKAY.
- Error flag is set when any of the following holds:
  - word index HADDR[ADDR_WIDTH-1:2] >= MEM_DEPTH;
  - HSIZE > 010;
  - halfword with HADDR[0]=1;
  - word with HADDR[1:0]!=0.
- State machine (data phase):
  - IDLE: HREADYOUT=1, HRESP=0.
    - Accept with error → ERR1.
    - Accept OK with WAIT_STATES>0 → WAIT, counter loaded with WAIT_STATES.
    - Accept OK with WAIT_STATES=0 → stay IDLE; the data phase completes next cycle.
  - WAIT: HREADYOUT=0. Counter decrements each cycle; at 1 → DONE.
  - DONE: HREADYOUT=1 for one cycle. This cycle is HREADY=1, so a new accept is evaluated exactly as in IDLE.
  - ERR1: HREADYOUT=0, HRESP=1, then → ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. A new address phase is accepted here too, and HTRANS=IDLE must be honoured.
- Latency: OKAY data phase lasts 1+WAIT_STATES cycles; ERROR always lasts 2 cycles. Pipelining is back-to-back: the next address phase overlaps the completing data phase.
- Write: commits on the edge that ends the completing data phase (HREADYOUT=1). Byte lanes are little-endian: byte lane = addr[1:0]; halfword lanes = addr[1] ? [31:16] : [15:0]. Unselected lanes are unchanged. An errored write never modifies memory.
- Read: HRDATA is registered and valid during the completing data-phase cycle. It holds its value at all other times, including during errors and IDLE; it is never driven X. The full word is returned; the master selects the lanes.
- Read-after-write hazard: the read's address phase coincides with the previous write's completion to the same word. The read must return the merged new data (write-data forwarding with byte enables), not the stale word.
- HSEL deasserted during a wait state: ignored. The transfer completes normally because HSEL is only sampled on the accept edge.
- HRESET asserted mid-transfer: takes effect on the next edge. The state returns to IDLE with HREADYOUT=1. A pending write is dropped and memory is unaltered by it.

Decomposition:
- ahb_pkg (shared across the bus interconnects):
  - htrans_t enum (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11);
  - HSIZE_BYTE/HALF/WORD constants;
  - HRESP_OKAY=0, HRESP_ERROR=1;
  - slave state enum {IDLE, WAIT, DONE, ERR1, ERR2}.
- Sub-module sram_bank: synchronous single-port RAM, MEM_DEPTH x 32, with a 4-bit byte-enable write and registered read. The control FSM, error decode, byte-enable generation and forwarding stay in ahb_sram_slave.

Test Plan:
- Reset release with WAIT_STATES=0 → HREADYOUT=1, HRESP=0, HRDATA=0. IDLE transfers with HSEL=1 → OKAY, zero wait.
- Word write 0xDEADBEEF at 0x10, then read 0x10 back-to-back → read data phase returns 0xDEADBEEF in 1 cycle (forwarding path).
- Byte write 0xAA at 0x13 over word 0x11223344, then word read 0x10 → 0xAA223344. Halfword write 0x5566 at 0x12 → 0x55663344.
- WAIT_STATES=2, word read → HREADYOUT low for exactly 2 cycles, then high with valid data. Next NONSEQ is accepted on the completing cycle.
- Word access at 0x102 (misaligned), HSIZE=011, and addr 0x400 with MEM_DEPTH=256 → each gives HRESP=1 with HREADYOUT 0 then 1. Memory is unchanged (verified by readback).
- HRESET pulsed during WAIT of a write to 0x20 holding 0x0 → outputs at reset values next cycle. Subsequent read of 0x20 → 0x0.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer types, size codes, response codes,
// memory-slave data-phase states and byte-lane helpers.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DONE = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } slave_state_t;

    // Little-endian lane enables for a legal size/offset; illegal sizes enable nothing.
    function automatic logic [3:0] byte_enables(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << addr_lo;
            HSIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: be = 4'b1111;
            default:    be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] base, input logic [31:0] upd,
                                                input logic [3:0] be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? upd[8*i +: 8] : base[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_bank.sv
// Synchronous 32-bit RAM with byte-enable write and registered read.
// Read and write addresses are separate because a write commit overlaps the next read's address phase.
module sram_bank #(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [3:0]               be,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [31:0]              wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [31:0]              rdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_r;

    // Byte-lane write; storage itself is never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Registered read returns the word as it was before any same-edge write.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= 32'h0000_0000;
        end else if (re) begin
            rdata_r <= mem[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: OKAY transfers with optional wait states, two-cycle ERROR,
// and write-data forwarding for a read whose address phase overlaps a write commit.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int         IDX_W  = $clog2(MEM_DEPTH);
    localparam logic [2:0] WAIT_L = 3'(WAIT_STATES);

    slave_state_t       state_r;
    slave_state_t       state_next_s;
    logic [2:0]         wait_cnt_r;
    logic [2:0]         wait_cnt_next_s;
    logic               ready_next_s;
    logic               resp_next_s;
    logic               hreadyout_r;
    logic               hresp_r;

    logic               addr_phase_s;
    logic               trans_active_s;
    logic               accept_s;
    logic               size_err_s;
    logic               range_err_s;
    logic               err_s;

    logic               valid_r;
    logic               err_r;
    logic               write_r;
    logic [2:0]         size_r;
    logic [IDX_W+1:0]   addr_r;

    logic               complete_s;
    logic               wr_en_s;
    logic               rd_en_s;
    logic               same_word_s;
    logic [3:0]         wr_be_s;
    logic [3:0]         fwd_be_r;
    logic [31:0]        fwd_data_r;
    logic [31:0]        ram_rdata_s;

    assign addr_phase_s   = HREADY && hreadyout_r;
    assign trans_active_s = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
    assign accept_s       = HSEL && addr_phase_s && trans_active_s;
    assign range_err_s    = |HADDR[ADDR_WIDTH-1:IDX_W+2];
    assign err_s          = size_err_s || range_err_s;

    // Size and alignment legality of the address phase.
    always_comb begin
        size_err_s = 1'b0;
        case (HSIZE)
            HSIZE_BYTE: size_err_s = 1'b0;
            HSIZE_HALF: size_err_s = HADDR[0];
            HSIZE_WORD: size_err_s = |HADDR[1:0];
            default:    size_err_s = 1'b1;
        endcase
    end

    // Data-phase next state, wait counter and the response that goes with the next state.
    always_comb begin
        state_next_s    = state_r;
        wait_cnt_next_s = wait_cnt_r;
        ready_next_s    = 1'b1;
        resp_next_s     = HRESP_OKAY;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR2: begin
                if (accept_s && err_s) begin
                    state_next_s = ST_ERR1;
                end else if (accept_s && (WAIT_L != 3'd0)) begin
                    state_next_s    = ST_WAIT;
                    wait_cnt_next_s = WAIT_L;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r <= 3'd1) begin
                    state_next_s    = ST_DONE;
                    wait_cnt_next_s = 3'd0;
                end else begin
                    wait_cnt_next_s = wait_cnt_r - 3'd1;
                end
            end
            ST_ERR1: state_next_s = ST_ERR2;
            default: state_next_s = ST_IDLE;
        endcase
        case (state_next_s)
            ST_IDLE, ST_DONE: begin
                ready_next_s = 1'b1;
                resp_next_s  = HRESP_OKAY;
            end
            ST_WAIT: begin
                ready_next_s = 1'b0;
                resp_next_s  = HRESP_OKAY;
            end
            ST_ERR1: begin
                ready_next_s = 1'b0;
                resp_next_s  = HRESP_ERROR;
            end
            ST_ERR2: begin
                ready_next_s = 1'b1;
                resp_next_s  = HRESP_ERROR;
            end
            default: begin
                ready_next_s = 1'b1;
                resp_next_s  = HRESP_OKAY;
            end
        endcase
    end

    // State, wait counter and registered handshake outputs.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_r     <= ST_IDLE;
            wait_cnt_r  <= 3'd0;
            hreadyout_r <= 1'b1;
            hresp_r     <= HRESP_OKAY;
        end else begin
            state_r     <= state_next_s;
            wait_cnt_r  <= wait_cnt_next_s;
            hreadyout_r <= ready_next_s;
            hresp_r     <= resp_next_s;
        end
    end

    // Address-phase capture; any other ready cycle leaves no transfer pending.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            write_r <= 1'b0;
            size_r  <= 3'b000;
            addr_r  <= {(IDX_W+2){1'b0}};
        end else if (addr_phase_s) begin
            valid_r <= accept_s;
            if (accept_s) begin
                err_r   <= err_s;
                write_r <= HWRITE;
                size_r  <= HSIZE;
                addr_r  <= HADDR[IDX_W+1:0];
            end
        end
    end

    // A legal transfer completes in the pending cycle where HREADYOUT is high.
    assign complete_s  = valid_r && !err_r && hreadyout_r;
    assign wr_en_s     = complete_s && write_r && !HRESET;
    assign wr_be_s     = byte_enables(size_r, addr_r[1:0]);
    assign rd_en_s     = accept_s && !HWRITE && !err_s && !HRESET;
    assign same_word_s = wr_en_s && (addr_r[IDX_W+1:2] == HADDR[IDX_W+1:2]);

    // Lanes of a same-edge write to the word being read override the stale RAM word.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            fwd_be_r   <= 4'b0000;
            fwd_data_r <= 32'h0000_0000;
        end else if (rd_en_s) begin
            fwd_be_r   <= same_word_s ? wr_be_s : 4'b0000;
            fwd_data_r <= HWDATA;
        end
    end

    sram_bank #(
        .DEPTH (MEM_DEPTH)
    ) u_bank (
        .clk   (HCLK),
        .rst   (HRESET),
        .we    (wr_en_s),
        .be    (wr_be_s),
        .waddr (addr_r[IDX_W+1:2]),
        .wdata (HWDATA),
        .re    (rd_en_s),
        .raddr (HADDR[IDX_W+1:2]),
        .rdata (ram_rdata_s)
    );

    assign HRDATA    = merge_lanes(ram_rdata_s, fwd_data_r, fwd_be_r);
    assign HREADYOUT = hreadyout_r;
    assign HRESP     = hresp_r;

endmodule
